pipelined_adder: RTL and testbench

Parametrised, pipelined carry-chain adder/subtractor. A WIDTH-bit operation is split into CHUNK-bit slices. Each pipeline stage adds one slice and registers its carry into the next stage, so carry propagation per cycle is bounded to CHUNK bits. A valid/ready handshake on both sides lets the block sit between streaming datapath stages in place of the flat combinational ripple adders. It also adds subtraction, signed overflow and zero flags.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_chunk.sv | 14 +
 rtl/pipelined_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_adder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: op encoding, depth helper and
// parameter legality check.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } adder_op_t;

    function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder with carry in and carry out.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage with a registered carry,
// valid/ready handshake and a global stall that freezes every stage.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES = stages(WIDTH, CHUNK);
    localparam int unsigned LAST   = STAGES - 1;

    if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    adder_op_t op;
    logic      stall;

    // Stage k inputs: operands still in flight, partial sum and incoming carry.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];
    logic [WIDTH-1:0] s_next [STAGES];

    logic [CHUNK-1:0] slice_s [STAGES];
    logic             slice_c [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic ovf_q;
    logic zero_q;
    logic ovf_next;
    logic zero_next;

    assign op       = sub ? OP_SUB : OP_ADD;
    assign stall    = v_q[LAST] && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        a_in[0] = a;
        b_in[0] = (op == OP_SUB) ? ~b : b;
        c_in[0] = (op == OP_SUB) ? 1'b1 : cin;
        s_in[0] = '0;
        v_in[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a   (a_in[k][k*CHUNK +: CHUNK]),
            .b   (b_in[k][k*CHUNK +: CHUNK]),
            .cin (c_in[k]),
            .s   (slice_s[k]),
            .cout(slice_c[k])
        );
    end

    // Flags use the top operand slice as it reaches the last stage, alongside
    // the fully assembled sum.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            s_next[k] = s_in[k];
            s_next[k][k*CHUNK +: CHUNK] = slice_s[k];
        end
        ovf_next  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                    (s_next[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
        zero_next = (s_next[LAST] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_next[k];
                    c_q[k] <= slice_c[k];
                end
            end
            if (v_in[LAST]) begin
                ovf_q  <= ovf_next;
                zero_q <= zero_next;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized self-checking bench for pipelined_adder over four WIDTH/CHUNK
// configurations, checked against an arithmetic reference model.
module tb_pipelined_adder;

    localparam int NDUT = 4;
    localparam int W   [NDUT] = '{32, 4, 4, 16};
    localparam int STG [NDUT] = '{4, 1, 4, 4};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
        int          st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        rdy     [NDUT];
    logic        o_valid [NDUT];
    logic        o_inrdy [NDUT];
    logic        o_cout  [NDUT];
    logic        o_ovf   [NDUT];
    logic        o_zero  [NDUT];
    logic [31:0] o_sum   [NDUT];

    logic [31:0] sum0;
    logic [3:0]  sum1;
    logic [3:0]  sum2;
    logic [15:0] sum3;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_tot [NDUT];
    bit   prev_stall [NDUT];
    logic [35:0] prev_out [NDUT];
    exp_t q [NDUT][$];
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_inrdy[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(o_valid[0]), .out_ready(rdy[0]),
        .sum(sum0), .cout(o_cout[0]), .ovf(o_ovf[0]), .zero(o_zero[0])
    );

    pipelined_adder #(.WIDTH(4), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_inrdy[1]),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .out_valid(o_valid[1]), .out_ready(rdy[1]),
        .sum(sum1), .cout(o_cout[1]), .ovf(o_ovf[1]), .zero(o_zero[1])
    );

    pipelined_adder #(.WIDTH(4), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_inrdy[2]),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .out_valid(o_valid[2]), .out_ready(rdy[2]),
        .sum(sum2), .cout(o_cout[2]), .ovf(o_ovf[2]), .zero(o_zero[2])
    );

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_inrdy[3]),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(o_valid[3]), .out_ready(rdy[3]),
        .sum(sum3), .cout(o_cout[3]), .ovf(o_ovf[3]), .zero(o_zero[3])
    );

    assign o_sum[0] = sum0;
    assign o_sum[1] = {28'd0, sum1};
    assign o_sum[2] = {28'd0, sum2};
    assign o_sum[3] = {16'd0, sum3};

    task automatic chk(input string name, input int dut, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, dut, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer arithmetic; ovf from the true signed result range.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic op_sub);
        exp_t   r;
        longint m, aa, bb, full, half, sa, sbv, t;
        m    = (longint'(1) << w) - 1;
        aa   = longint'({32'd0, av}) & m;
        bb   = longint'({32'd0, bv}) & m;
        full = op_sub ? (aa + (m - bb) + 1) : (aa + bb + longint'(ci));
        half = longint'(1) << (w - 1);
        sa   = (aa >= half) ? aa - 2 * half : aa;
        sbv  = (bb >= half) ? bb - 2 * half : bb;
        t    = op_sub ? (sa - sbv) : (sa + sbv + longint'(ci));
        r.sum  = 32'(full & m);
        r.cout = op_sub ? (aa >= bb) : (((full >> w) & 1) != 0);
        r.ovf  = (t < -half) || (t >= half);
        r.zero = (r.sum == 32'd0);
        r.cyc  = 0;
        r.st   = 0;
        return r;
    endfunction

    function automatic logic [35:0] outs(input int i);
        return {o_valid[i], o_cout[i], o_ovf[i], o_zero[i], o_sum[i]};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   stall;
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                q[i].delete();
                prev_stall[i] = 1'b0;
                chk("reset_outputs", i, 64'(outs(i)), 64'd0);
                chk("reset_in_ready", i, 64'(o_inrdy[i]), 64'd1);
            end else begin
                stall = o_valid[i] && !rdy[i];
                chk("in_ready", i, 64'(o_inrdy[i]), 64'(!stall));
                if (prev_stall[i])
                    chk("stall_hold", i, 64'(outs(i)), 64'(prev_out[i]));
                if (o_valid[i] && rdy[i]) begin
                    if (q[i].size() == 0) begin
                        chk("spurious_output", i, 64'(o_valid[i]), 64'd0);
                    end else begin
                        e = q[i].pop_front();
                        chk("result", i, {28'd0, o_cout[i], o_ovf[i], o_zero[i], o_sum[i]},
                            {28'd0, e.cout, e.ovf, e.zero, e.sum});
                        chk("latency", i, 64'(cyc - e.cyc), 64'(STG[i] + stall_tot[i] - e.st));
                    end
                end
                if (in_valid && o_inrdy[i]) begin
                    e = model(W[i], a, b, cin, sub);
                    e.cyc = cyc;
                    e.st  = stall_tot[i];
                    q[i].push_back(e);
                end
                if (stall) stall_tot[i]++;
                prev_stall[i] = stall;
                prev_out[i]   = outs(i);
            end
        end
        cyc++;
    end

    initial begin : ready_driver
        for (int i = 0; i < NDUT; i++) rdy[i] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++)
                rdy[i] = rand_rdy ? ($urandom_range(2) != 0) : 1'b1;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 just after the accepting edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic op_sub);
        bit done;
        a = av; b = bv; cin = ci; sub = op_sub;
        in_valid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (o_inrdy[0]) done = 1'b1;
        end
        if (!done) timeout_fail("accept");
        sync();
        in_valid = 1'b0;
    endtask

    task automatic expect_main(input string name, input logic [31:0] s, input logic co,
                               input logic ov, input logic z);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid[0] && n < 20);
        chk({name, "_latency"}, 0, 64'(n), 64'd4);
        chk({name, "_result"}, 0, {29'd0, o_cout[0], o_ovf[0], o_zero[0], o_sum[0]},
            {29'd0, co, ov, z, s});
        sync();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : main
        exp_t m;
        bit   drained;
        for (int i = 0; i < NDUT; i++) begin
            stall_tot[i] = 0;
            prev_stall[i] = 1'b0;
            prev_out[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        sync();

        m = model(32, 32'h0000_00FF, 32'h1, 1'b0, 1'b0);
        chk("model_carry", 0, {29'd0, m.cout, m.ovf, m.zero, m.sum}, {29'd0, 3'b000, 32'h0000_0100});
        m = model(32, 32'd5, 32'd9, 1'b0, 1'b1);
        chk("model_sub", 0, {29'd0, m.cout, m.ovf, m.zero, m.sum}, {29'd0, 3'b000, 32'hFFFF_FFFC});
        m = model(4, 32'h8, 32'h1, 1'b0, 1'b1);
        chk("model_sub_ovf", 1, {29'd0, m.cout, m.ovf, m.zero, m.sum}, {29'd0, 3'b110, 32'h7});
        m = model(16, 32'h8000, 32'h8000, 1'b0, 1'b0);
        chk("model_add_ovf", 3, {29'd0, m.cout, m.ovf, m.zero, m.sum}, {29'd0, 3'b111, 32'h0});
        m = model(4, 32'hF, 32'h0, 1'b1, 1'b0);
        chk("model_ripple", 1, {29'd0, m.cout, m.ovf, m.zero, m.sum}, {29'd0, 3'b101, 32'h0});

        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        expect_main("carry_chunk", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        expect_main("full_ripple", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        expect_main("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        issue(32'd5, 32'd9, 1'b0, 1'b1);
        expect_main("sub_borrow", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        issue(32'd9, 32'd5, 1'b1, 1'b1);
        expect_main("sub_no_borrow", 32'd4, 1'b1, 1'b0, 1'b0);

        issue(32'd1, 32'd2, 1'b0, 1'b0);
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        issue(32'd5, 32'd6, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 0, 64'(outs(0)), 64'd0);
        sync();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("no_stale_after_reset", 0, 64'(o_valid[0]), 64'd0);
        end
        sync();
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        expect_main("post_reset", 32'h0123_4567, 1'b1, 1'b0, 1'b0);

        rand_rdy = 1'b1;
        for (int n = 0; n < 20; n++)
            issue(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int n = 0; n < 300; n++) begin
            issue(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) sync();
        end
        rand_rdy = 1'b0;

        drained = 1'b0;
        for (int n = 0; n < 100 && !drained; n++) begin
            @(negedge clk);
            drained = (q[0].size() == 0) && (q[1].size() == 0) &&
                      (q[2].size() == 0) && (q[3].size() == 0);
        end
        if (!drained) timeout_fail("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
